// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program sequencer: lifecycle states and
// the branch flag-select encoding used by the decoder.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [1:0] BSEL_EQ    = 2'b00;
  localparam logic [1:0] BSEL_LT    = 2'b01;
  localparam logic [1:0] BSEL_OVF   = 2'b10;
  localparam logic [1:0] BSEL_START = 2'b11;

endpackage

// File: rtl/pc_sequencer_branch_resolve.sv
// Combinational branch resolution: picks the flag named by branch_sel and
// produces the next sequential or branch-target program counter.
module branch_resolve
  import seq_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int OFF_W = 6
) (
  input  logic [PC_W-1:0]  pc_i,
  input  logic             branch_i,
  input  logic [1:0]       branch_sel_i,
  input  logic             flag_eq_i,
  input  logic             flag_lt_i,
  input  logic             flag_ovf_i,
  input  logic             use_lut_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [PC_W-1:0]  lut_target_i,
  output logic             taken_o,
  output logic [PC_W-1:0]  next_pc_o
);

  logic            sel_flag;
  logic [PC_W-1:0] offset_ext;
  logic [PC_W-1:0] target;

  always_comb begin
    sel_flag = 1'b0;
    case (branch_sel_i)
      BSEL_EQ:    sel_flag = flag_eq_i;
      BSEL_LT:    sel_flag = flag_lt_i;
      BSEL_OVF:   sel_flag = flag_ovf_i;
      BSEL_START: sel_flag = 1'b0;  // start marker behaves as a nop
      default:    sel_flag = 1'b0;
    endcase
  end

  // Sum is truncated to PC_W bits, so negative offsets wrap around naturally.
  assign offset_ext = {{(PC_W-OFF_W){offset_i[OFF_W-1]}}, offset_i};
  assign target     = use_lut_i ? lut_target_i : (pc_i + offset_ext);
  assign taken_o    = branch_i & sel_flag;
  assign next_pc_o  = taken_o ? target : (pc_i + PC_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: owns the PC, runs the IDLE/RUN/WAIT/HALT lifecycle,
// resolves branches, stalls for memory reads and gates architectural writes.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int OFF_W   = 6,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             ctrl_branch,
  input  logic             ctrl_done,
  input  logic             ctrl_mem_rd,
  input  logic [1:0]       branch_sel,
  input  logic             use_lut,
  input  logic [OFF_W-1:0] offset,
  input  logic [PC_W-1:0]  lut_target,
  input  logic             flag_eq,
  input  logic             flag_lt,
  input  logic             flag_ovf,
  output logic [PC_W-1:0]  pc,
  output logic             commit_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output state_t           state_o
);

  localparam int WAIT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
  localparam bit STALL_EN = (MEM_LAT > 0);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              done_q, done_d;
  logic              go_q;
  logic              go_edge;
  logic              commit_raw, stall_raw;
  logic              br_branch;
  logic              br_taken;
  logic [PC_W-1:0]   br_next_pc;

  assign go_edge = go & ~go_q;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  // done and mem_rd outrank a branch if decode ever asserts more than one.
  assign br_branch = ctrl_branch & ~ctrl_done & ~ctrl_mem_rd;

  branch_resolve #(
    .PC_W (PC_W),
    .OFF_W(OFF_W)
  ) u_branch_resolve (
    .pc_i        (pc_q),
    .branch_i    (br_branch),
    .branch_sel_i(branch_sel),
    .flag_eq_i   (flag_eq),
    .flag_lt_i   (flag_lt),
    .flag_ovf_i  (flag_ovf),
    .use_lut_i   (use_lut),
    .offset_i    (offset),
    .lut_target_i(lut_target),
    .taken_o     (br_taken),
    .next_pc_o   (br_next_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    done_d     = done_q;
    commit_raw = 1'b0;
    stall_raw  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_edge) begin
          pc_d    = start_addr;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (ctrl_done) begin
          done_d  = 1'b1;
          state_d = S_HALT;
        end else if (ctrl_mem_rd && STALL_EN) begin
          stall_raw = 1'b1;
          wait_d    = WAIT_INIT;
          state_d   = S_WAIT;
        end else begin
          commit_raw = 1'b1;
          pc_d       = br_next_pc;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (wait_q != '0) begin
          stall_raw = 1'b1;
          wait_d    = wait_q - WAIT_W'(1);
        end else begin
          // Final cycle of the load: write back, then resume at the next word.
          commit_raw = 1'b1;
          pc_d       = pc_q + PC_W'(1);
          state_d    = S_RUN;
        end
      end
      S_HALT: begin
        if (go_edge) begin
          done_d  = 1'b0;
          pc_d    = start_addr;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      go_q    <= go;
    end
  end

  // Reset suppresses writes in the same cycle it is asserted.
  assign commit_o  = commit_raw & ~reset;
  assign stall_o   = stall_raw & ~reset;
  assign pc        = pc_q;
  assign done_o    = done_q;
  assign cycle_cnt = cnt_q;
  assign state_o   = state_q;

  logic unused_taken;
  assign unused_taken = br_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random instruction streams,
// all compared against a cycle-level behavioural model of the program flow.
module tb_pc_sequencer;
  import seq_pkg::*;

  localparam int PC_W    = 10;
  localparam int OFF_W   = 6;
  localparam int MEM_LAT = 2;
  localparam int CNT_W   = 16;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             go = 1'b0;
  logic [PC_W-1:0]  start_addr = '0;
  logic             ctrl_branch = 1'b0;
  logic             ctrl_done = 1'b0;
  logic             ctrl_mem_rd = 1'b0;
  logic [1:0]       branch_sel = 2'b00;
  logic             use_lut = 1'b0;
  logic [OFF_W-1:0] offset = '0;
  logic [PC_W-1:0]  lut_target = '0;
  logic             flag_eq = 1'b0;
  logic             flag_lt = 1'b0;
  logic             flag_ovf = 1'b0;
  logic [PC_W-1:0]  pc;
  logic             commit_o;
  logic             stall_o;
  logic             done_o;
  logic [CNT_W-1:0] cycle_cnt;
  state_t           dbg_state;

  pc_sequencer #(
    .PC_W(PC_W), .OFF_W(OFF_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .start_addr(start_addr),
    .ctrl_branch(ctrl_branch), .ctrl_done(ctrl_done), .ctrl_mem_rd(ctrl_mem_rd),
    .branch_sel(branch_sel), .use_lut(use_lut), .offset(offset),
    .lut_target(lut_target), .flag_eq(flag_eq), .flag_lt(flag_lt),
    .flag_ovf(flag_ovf), .pc(pc), .commit_o(commit_o), .stall_o(stall_o),
    .done_o(done_o), .cycle_cnt(cycle_cnt), .state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [PC_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Program-level view: running or not, how many load cycles remain, and
  // the architectural pc / counter / done indication.
  int m_pc = 0;
  int m_cnt = 0;
  int m_load = 0;
  bit m_run = 0;
  bit m_done = 0;
  bit m_go_prev = 0;

  function automatic int wrap_pc(input int v);
    return ((v % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  function automatic bit flag_selected();
    case (branch_sel)
      2'b00:   return flag_eq;
      2'b01:   return flag_lt;
      2'b10:   return flag_ovf;
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle: compare at the falling edge, advance model, return
  // just after the rising edge so the caller can drive the next inputs.
  task automatic tick();
    bit exp_commit;
    bit exp_stall;
    bit go_edge;
    @(negedge clk);
    if (exp_q.size() > 0) check("pc", 32'(pc), 32'(exp_q.pop_front()));
    check("done_o", 32'(done_o), 32'(m_done));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    exp_commit = 1'b0;
    exp_stall  = 1'b0;
    go_edge    = go && !m_go_prev;
    if (reset) begin
      m_pc = 0; m_cnt = 0; m_load = 0; m_run = 0; m_done = 0; m_go_prev = 0;
    end else begin
      if (m_load > 0) begin
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        if (m_load == 1) begin
          exp_commit = 1'b1;
          m_pc = wrap_pc(m_pc + 1);
        end else begin
          exp_stall = 1'b1;
        end
        m_load--;
      end else if (m_run) begin
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        if (ctrl_done) begin
          m_done = 1; m_run = 0;
        end else if (ctrl_mem_rd && MEM_LAT > 0) begin
          exp_stall = 1'b1;
          m_load = MEM_LAT;
        end else begin
          exp_commit = 1'b1;
          if (ctrl_branch && flag_selected())
            m_pc = use_lut ? int'(lut_target) : wrap_pc(m_pc + int'($signed(offset)));
          else
            m_pc = wrap_pc(m_pc + 1);
        end
      end else if (go_edge) begin
        m_pc = int'(start_addr); m_cnt = 0; m_done = 0; m_run = 1;
      end
      m_go_prev = go;
    end
    check("commit_o", 32'(commit_o), 32'(exp_commit));
    check("stall_o", 32'(stall_o), 32'(exp_stall));
    exp_q.push_back(PC_W'(m_pc));
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_nop();
    ctrl_branch = 0; ctrl_done = 0; ctrl_mem_rd = 0; use_lut = 0;
    branch_sel = 2'b00; flag_eq = 0; flag_lt = 0; flag_ovf = 0;
  endtask

  task automatic drive_jump(input logic [PC_W-1:0] tgt);
    drive_nop();
    ctrl_branch = 1; use_lut = 1; lut_target = tgt; branch_sel = BSEL_EQ; flag_eq = 1;
  endtask

  task automatic drive_random();
    int r;
    r = $urandom_range(0, 99);
    reset = ($urandom_range(0, 199) == 0);
    if ($urandom_range(0, 19) == 0) go = ~go;
    start_addr  = PC_W'($urandom);
    ctrl_done   = (r < 3);
    ctrl_mem_rd = (r >= 3 && r < 18) || (r >= 95);
    ctrl_branch = (r >= 18 && r < 60) || (r >= 93);
    branch_sel  = 2'($urandom);
    use_lut     = 1'($urandom);
    offset      = OFF_W'($urandom);
    lut_target  = PC_W'($urandom);
    flag_eq     = 1'($urandom);
    flag_lt     = 1'($urandom);
    flag_ovf    = 1'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_q.push_back('0);
    drive_nop();
    reset = 1;
    tick();
    tick();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_cnt", 32'(cycle_cnt), 32'h0);
    check("rst_commit", 32'(commit_o), 32'h0);
    reset = 0;

    // straight-line run from 0x010
    go = 1; start_addr = 10'h010;
    tick();
    check("t1_pc0", 32'(pc), 32'h010);
    #1 check("t1_commit", 32'(commit_o), 32'h1);
    tick();
    check("t1_pc1", 32'(pc), 32'h011);
    tick();
    check("t1_pc2", 32'(pc), 32'h012);

    // relative branch, taken and not taken
    drive_jump(10'h020);
    tick();
    check("t2_at20", 32'(pc), 32'h020);
    drive_nop(); ctrl_branch = 1; branch_sel = BSEL_EQ; flag_eq = 1; offset = 6'b111100;
    tick();
    check("t2_taken", 32'(pc), 32'h01C);
    drive_jump(10'h020);
    tick();
    drive_nop(); ctrl_branch = 1; branch_sel = BSEL_EQ; flag_eq = 0; offset = 6'b111100;
    tick();
    check("t2_not_taken", 32'(pc), 32'h021);

    // LUT target and start-marker select
    drive_nop(); ctrl_branch = 1; use_lut = 1; lut_target = 10'h3F0; branch_sel = BSEL_LT; flag_lt = 1;
    tick();
    check("t3_lut", 32'(pc), 32'h3F0);
    branch_sel = BSEL_START; flag_eq = 1; flag_ovf = 1;
    tick();
    check("t3_start_nop", 32'(pc), 32'h3F1);

    // memory read stall at 0x005
    drive_jump(10'h005);
    tick();
    drive_nop(); ctrl_mem_rd = 1;
    #1 check("t4_stall0", 32'(stall_o), 32'h1);
    check("t4_commit0", 32'(commit_o), 32'h0);
    tick();
    check("t4_pc_hold1", 32'(pc), 32'h005);
    check("t4_stall1", 32'(stall_o), 32'h1);
    check("t4_commit1", 32'(commit_o), 32'h0);
    tick();
    check("t4_pc_hold2", 32'(pc), 32'h005);
    check("t4_wb_commit", 32'(commit_o), 32'h1);
    check("t4_wb_stall", 32'(stall_o), 32'h0);
    drive_nop();
    tick();
    check("t4_pc_next", 32'(pc), 32'h006);

    // done after 7 RUN cycles with go held high, then restart
    ctrl_done = 1;
    tick();
    drive_nop(); go = 0;
    tick();
    go = 1; start_addr = 10'h000;
    tick();
    for (int i = 0; i < 6; i++) tick();
    ctrl_done = 1;
    tick();
    drive_nop();
    tick();
    tick();
    check("t5_done", 32'(done_o), 32'h1);
    check("t5_pc_frozen", 32'(pc), 32'h006);
    check("t5_cnt", 32'(cycle_cnt), 32'h7);
    go = 0;
    tick();
    go = 1; start_addr = 10'h000;
    tick();
    check("t5_restart_done", 32'(done_o), 32'h0);
    check("t5_restart_pc", 32'(pc), 32'h0);
    check("t5_restart_cnt", 32'(cycle_cnt), 32'h0);

    // wrap at top of address space, then reset mid-WAIT
    drive_jump(10'h3FF);
    tick();
    drive_nop();
    tick();
    check("t6_wrap", 32'(pc), 32'h000);
    ctrl_mem_rd = 1;
    tick();
    drive_nop(); reset = 1;
    tick();
    reset = 0; go = 1;
    #1 check("t6_rst_commit", 32'(commit_o), 32'h0);
    check("t6_rst_pc", 32'(pc), 32'h0);
    check("t6_rst_done", 32'(done_o), 32'h0);
    tick();

    // random instruction streams
    for (int n = 0; n < 4000; n++) begin
      drive_random();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL timeout: simulation exceeded its time budget");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
